// File: rtl/cache_wb.sv
// Set-associative write-back, write-allocate data cache (VIPT) with line refill/writeback FSM.
// Latency: hits resolve combinationally; a clean miss stalls 2 cycles, a dirty miss adds WRITEBACK.
// Backpressure: o_stall holds the pipeline while a miss is serviced; memory paces via i_mem_ack.
// Optional macro CACHE_WB_PLRU_EN: tree pseudo-LRU replacement instead of the external rnd way.
module cache_wb #(
    parameter int N_SETS     = 4,
    parameter int N_WAYS     = 2,
    parameter int N_ELEMENTS = 4,
    parameter int N_BYTES    = 4,
    parameter int VA_WIDTH   = 32,
    parameter int PA_WIDTH   = 32,
    localparam int WAY_W     = $clog2(N_WAYS),
    localparam int ELEMENT_W = 8 * N_BYTES,
    localparam int LINE_W    = N_ELEMENTS * ELEMENT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WAY_W-1:0]     rnd,
    input  logic                 i_is_load,
    input  logic                 i_is_store,
    input  logic [VA_WIDTH-1:0]  i_va_addr,
    input  logic [PA_WIDTH-1:0]  i_pa_addr,
    input  logic [ELEMENT_W-1:0] i_write_data,
    input  logic [N_BYTES-1:0]   i_byte_en,
    output logic                 o_hit,
    output logic                 o_stall,
    output logic [ELEMENT_W-1:0] o_read_data,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [PA_WIDTH-1:0]  o_mem_addr,
    output logic [LINE_W-1:0]    o_mem_wdata,
    input  logic                 i_mem_ack,
    input  logic [LINE_W-1:0]    i_mem_rdata
);
    localparam int IDX_W  = $clog2(N_SETS);
    localparam int OFF_W  = $clog2(N_ELEMENTS * N_BYTES);
    localparam int BOFF_W = $clog2(N_BYTES);
    localparam int EL_W   = $clog2(N_ELEMENTS);
    localparam int TAG_W  = PA_WIDTH - OFF_W - IDX_W;
    localparam int PLN_W  = PA_WIDTH - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

    state_t              r_state, w_next;
    logic [N_WAYS-1:0]   r_valid [N_SETS];
    logic [N_WAYS-1:0]   r_dirty [N_SETS];
    logic [TAG_W-1:0]    r_tag   [N_SETS][N_WAYS];
    logic [LINE_W-1:0]   r_line  [N_SETS][N_WAYS];
    logic [WAY_W-1:0]    r_vic;
    logic [IDX_W-1:0]    r_idx;
    logic [PLN_W-1:0]    r_pa_line;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [EL_W-1:0]     w_elem;
    logic                w_req, w_lookup, w_miss;
    logic                w_hit_any, w_inv_any;
    logic [WAY_W-1:0]    w_hit_way, w_inv_way, w_victim;
    logic                w_unused;

    assign w_idx  = i_va_addr[OFF_W +: IDX_W];
    assign w_tag  = i_pa_addr[PA_WIDTH-1 -: TAG_W];
    assign w_elem = i_pa_addr[BOFF_W +: EL_W];
    assign w_req  = i_is_load | i_is_store;

`ifdef CACHE_WB_PLRU_EN
    // Heap-ordered tree: node n at bit n (bit 0 unused); a node bit points at the side to evict next.
    logic [N_WAYS-1:0]   r_plru [N_SETS];

    function automatic logic [WAY_W-1:0] plru_victim(input logic [N_WAYS-1:0] t);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        node = WAY_W'(1);
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            way[WAY_W-1-l] = t[node];
            node = (node << 1) | WAY_W'(t[node]);
        end
        return way;
    endfunction

    function automatic logic [N_WAYS-1:0] plru_touch(input logic [N_WAYS-1:0] t,
                                                     input logic [WAY_W-1:0]  way);
        logic [WAY_W-1:0]  node;
        logic [N_WAYS-1:0] res;
        node = WAY_W'(1);
        res  = t;
        for (int l = 0; l < WAY_W; l++) begin
            res[node] = ~way[WAY_W-1-l];
            node = (node << 1) | WAY_W'(way[WAY_W-1-l]);
        end
        return res;
    endfunction

    assign w_victim = w_inv_any ? w_inv_way : plru_victim(r_plru[w_idx]);
    assign w_unused = ^{i_va_addr[VA_WIDTH-1:OFF_W+IDX_W], i_va_addr[OFF_W-1:0],
                        i_pa_addr[BOFF_W-1:0], rnd};
`else
    assign w_victim = w_inv_any ? w_inv_way : rnd;
    assign w_unused = ^{i_va_addr[VA_WIDTH-1:OFF_W+IDX_W], i_va_addr[OFF_W-1:0],
                        i_pa_addr[BOFF_W-1:0]};
`endif

    // Tag match and lowest-index invalid way in the addressed set
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_inv_any = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
    end

    // Lookups only happen in IDLE and out of reset; everything else is a stall.
    assign w_lookup    = rst && (r_state == S_IDLE) && w_req;
    assign o_hit       = w_lookup && w_hit_any;
    assign w_miss      = w_lookup && !w_hit_any;
    assign o_stall     = rst && ((r_state != S_IDLE) || (w_req && !w_hit_any));
    assign o_read_data = o_hit ? r_line[w_idx][w_hit_way][w_elem*ELEMENT_W +: ELEMENT_W] : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next state and memory-side request outputs
    always_comb begin
        w_next      = r_state;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_miss)
                    w_next = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                             ? S_WRITEBACK : S_REFILL;
            end
            S_WRITEBACK: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {r_tag[r_idx][r_vic], r_idx, {OFF_W{1'b0}}};
                o_mem_wdata = r_line[r_idx][r_vic];
                if (i_mem_ack) w_next = S_REFILL;
            end
            S_REFILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = {r_pa_line, {OFF_W{1'b0}}};
                if (i_mem_ack) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Line status bits, replacement state and the latched miss context
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < N_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
`ifdef CACHE_WB_PLRU_EN
                r_plru[s]  <= '0;
`endif
            end
            r_vic     <= '0;
            r_idx     <= '0;
            r_pa_line <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (o_hit) begin
                        if (i_is_store) r_dirty[w_idx][w_hit_way] <= 1'b1;
`ifdef CACHE_WB_PLRU_EN
                        r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
`endif
                    end
                    if (w_miss) begin
                        r_vic     <= w_victim;
                        r_idx     <= w_idx;
                        r_pa_line <= i_pa_addr[PA_WIDTH-1:OFF_W];
                    end
                end
                S_WRITEBACK: begin
                    if (i_mem_ack) r_dirty[r_idx][r_vic] <= 1'b0;
                end
                S_REFILL: begin
                    if (i_mem_ack) begin
                        r_valid[r_idx][r_vic] <= 1'b1;
                        r_dirty[r_idx][r_vic] <= 1'b0;
`ifdef CACHE_WB_PLRU_EN
                        r_plru[r_idx] <= plru_touch(r_plru[r_idx], r_vic);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Line data and tags: never cleared, only written by store hits and refill completion
    always_ff @(posedge clk) begin
        if (o_hit && i_is_store) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (i_byte_en[b])
                    r_line[w_idx][w_hit_way][(int'(w_elem)*N_BYTES + b)*8 +: 8] <= i_write_data[b*8 +: 8];
            end
        end
        if (rst && (r_state == S_REFILL) && i_mem_ack) begin
            r_line[r_idx][r_vic] <= i_mem_rdata;
            r_tag[r_idx][r_vic]  <= r_pa_line[PLN_W-1 -: TAG_W];
        end
    end

endmodule

// File: tb/tb_cache_wb.sv
// Directed bench for cache_wb: refill, store hit merge, writeback, clean miss, store miss,
// stray ack, reset during a transfer and victim selection (expectation follows CACHE_WB_PLRU_EN).
module tb_cache_wb;
    logic         clk = 1'b0;
    logic         rst;
    logic [0:0]   rnd;
    logic         i_is_load, i_is_store;
    logic [31:0]  i_va_addr, i_pa_addr, i_write_data;
    logic [3:0]   i_byte_en;
    logic         o_hit, o_stall, o_mem_req, o_mem_we, i_mem_ack;
    logic [31:0]  o_read_data, o_mem_addr;
    logic [127:0] o_mem_wdata, i_mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] L1 = {32'h4, 32'h3, 32'h2, 32'h1};
    localparam logic [127:0] L2 = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    localparam logic [127:0] L3 = {32'h34, 32'h33, 32'h32, 32'h33};
    localparam logic [127:0] L4 = {32'h47, 32'h46, 32'h45, 32'h44};
    localparam logic [127:0] LJ = {4{32'h5555AAAA}};

    cache_wb dut (
        .clk(clk), .rst(rst), .rnd(rnd),
        .i_is_load(i_is_load), .i_is_store(i_is_store),
        .i_va_addr(i_va_addr), .i_pa_addr(i_pa_addr),
        .i_write_data(i_write_data), .i_byte_en(i_byte_en),
        .o_hit(o_hit), .o_stall(o_stall), .o_read_data(o_read_data),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_req();
        i_is_load = 1'b0; i_is_store = 1'b0;
    endtask

    task automatic load(input logic [31:0] pa, input logic [31:0] va);
        i_is_load = 1'b1; i_is_store = 1'b0; i_pa_addr = pa; i_va_addr = va;
    endtask

    task automatic store(input logic [31:0] pa, input logic [31:0] va,
                         input logic [31:0] d, input logic [3:0] be);
        i_is_load = 1'b0; i_is_store = 1'b1; i_pa_addr = pa; i_va_addr = va;
        i_write_data = d; i_byte_en = be;
    endtask

    // Stimulus only: service a clean miss with the ack in the first REFILL cycle
    task automatic fill(input logic [31:0] pa, input logic [31:0] va, input logic [127:0] line);
        tick(); load(pa, va);
        tick(); i_mem_ack = 1'b1; i_mem_rdata = line;
        tick(); i_mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; load(32'h10000010, 32'h10);
        tick(); tick();
        @(negedge clk);
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%0b exp=0", o_stall); end
        n_vec++; if (o_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit got=%0b exp=0", o_hit); end
        n_vec++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%0b exp=0", o_mem_req); end
        n_vec++; if (o_mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%0b exp=0", o_mem_we); end
        n_vec++; if (o_mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", o_mem_addr); end
        n_vec++; if (o_mem_wdata !== 128'h0) begin n_err++; $display("FAIL rst_wdata got=%h exp=0", o_mem_wdata); end
        tick(); rst = 1'b1; no_req();
        @(negedge clk);
        n_vec++; if ({o_hit, o_stall, o_mem_req} !== 3'b000) begin n_err++; $display("FAIL idle_outs got=%b exp=000", {o_hit, o_stall, o_mem_req}); end
    endtask

    task automatic test_refill();
        tick(); load(32'h10000010, 32'h10);
        @(negedge clk);
        n_vec++; if ({o_stall, o_hit, o_mem_req} !== 3'b100) begin n_err++; $display("FAIL detect stall/hit/req got=%b exp=100", {o_stall, o_hit, o_mem_req}); end
        tick();
        @(negedge clk);
        n_vec++; if ({o_stall, o_mem_req, o_mem_we} !== 3'b110) begin n_err++; $display("FAIL refill stall/req/we got=%b exp=110", {o_stall, o_mem_req, o_mem_we}); end
        n_vec++; if (o_mem_addr !== 32'h10000010) begin n_err++; $display("FAIL refill_addr got=%h exp=10000010", o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = L1;
        tick(); i_mem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if ({o_hit, o_stall} !== 2'b10) begin n_err++; $display("FAIL post_refill hit/stall got=%b exp=10", {o_hit, o_stall}); end
        n_vec++; if (o_read_data !== 32'h1) begin n_err++; $display("FAIL post_refill_data got=%h exp=00000001", o_read_data); end
    endtask

    task automatic test_store_hit();
        tick(); store(32'h10000010, 32'h10, 32'hDEADBEEF, 4'b0011);
        @(negedge clk);
        n_vec++; if ({o_hit, o_stall} !== 2'b10) begin n_err++; $display("FAIL store_hit hit/stall got=%b exp=10", {o_hit, o_stall}); end
        tick(); load(32'h10000010, 32'h10);
        @(negedge clk);
        n_vec++; if (o_read_data !== 32'h0000BEEF) begin n_err++; $display("FAIL store_merge got=%h exp=0000BEEF", o_read_data); end
        tick(); load(32'h10000014, 32'h14);
        @(negedge clk);
        n_vec++; if (o_read_data !== 32'h2) begin n_err++; $display("FAIL elem1_load got=%h exp=00000002", o_read_data); end
    endtask

    task automatic test_writeback();
        rnd = 1'b0;
        fill(32'h20000010, 32'h10, L2);
        @(negedge clk);
        n_vec++; if (o_read_data !== 32'hA1 || o_hit !== 1'b1) begin n_err++; $display("FAIL way1_fill hit=%0b data=%h exp 1/000000A1", o_hit, o_read_data); end
        tick(); load(32'h30000010, 32'h10);
        @(negedge clk);
        n_vec++; if ({o_stall, o_hit} !== 2'b10) begin n_err++; $display("FAIL dirty_detect stall/hit got=%b exp=10", {o_stall, o_hit}); end
        tick();
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_mem_we} !== 2'b11) begin n_err++; $display("FAIL wb req/we got=%b exp=11", {o_mem_req, o_mem_we}); end
        n_vec++; if (o_mem_addr !== 32'h10000010) begin n_err++; $display("FAIL wb_addr got=%h exp=10000010", o_mem_addr); end
        n_vec++; if (o_mem_wdata[63:0] !== 64'h00000002_0000BEEF) begin n_err++; $display("FAIL wb_wdata got=%h exp=000000020000BEEF", o_mem_wdata[63:0]); end
        tick();
        @(negedge clk);
        n_vec++; if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h10000010) begin n_err++; $display("FAIL wb_hold we=%0b addr=%h exp 1/10000010", o_mem_we, o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = LJ;
        tick(); i_mem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_mem_we, o_stall} !== 3'b101) begin n_err++; $display("FAIL wb_to_refill req/we/stall got=%b exp=101", {o_mem_req, o_mem_we, o_stall}); end
        n_vec++; if (o_mem_addr !== 32'h30000010) begin n_err++; $display("FAIL wb_refill_addr got=%h exp=30000010", o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = L3;
        tick(); i_mem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (o_hit !== 1'b1 || o_read_data !== 32'h33) begin n_err++; $display("FAIL wb_final hit=%0b data=%h exp 1/00000033", o_hit, o_read_data); end
    endtask

    task automatic test_clean_miss();
        tick(); rnd = 1'b1; load(32'h40000010, 32'h10);
        @(negedge clk);
        n_vec++; if ({o_stall, o_mem_we} !== 2'b10) begin n_err++; $display("FAIL clean_detect stall/we got=%b exp=10", {o_stall, o_mem_we}); end
        tick();
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_mem_we} !== 2'b10) begin n_err++; $display("FAIL clean_refill req/we got=%b exp=10", {o_mem_req, o_mem_we}); end
        n_vec++; if (o_mem_addr !== 32'h40000010) begin n_err++; $display("FAIL clean_addr got=%h exp=40000010", o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = L4;
        tick(); i_mem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (o_hit !== 1'b1 || o_read_data !== 32'h44) begin n_err++; $display("FAIL clean_final hit=%0b data=%h exp 1/00000044", o_hit, o_read_data); end
        tick(); load(32'h30000010, 32'h10);
        @(negedge clk);
        n_vec++; if (o_hit !== 1'b1 || o_read_data !== 32'h33) begin n_err++; $display("FAIL way0_kept hit=%0b data=%h exp 1/00000033", o_hit, o_read_data); end
    endtask

    task automatic test_store_miss();
        tick(); store(32'h50000020, 32'h20, 32'h11223344, 4'b1111);
        @(negedge clk);
        n_vec++; if ({o_stall, o_hit} !== 2'b10) begin n_err++; $display("FAIL smiss_detect stall/hit got=%b exp=10", {o_stall, o_hit}); end
        tick();
        @(negedge clk);
        n_vec++; if (o_mem_addr !== 32'h50000020 || o_mem_we !== 1'b0) begin n_err++; $display("FAIL smiss_refill addr=%h we=%0b exp 50000020/0", o_mem_addr, o_mem_we); end
        i_mem_ack = 1'b1; i_mem_rdata = L1;
        tick(); i_mem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if ({o_hit, o_stall} !== 2'b10) begin n_err++; $display("FAIL smiss_hit hit/stall got=%b exp=10", {o_hit, o_stall}); end
        tick(); load(32'h50000020, 32'h20);
        @(negedge clk);
        n_vec++; if (o_read_data !== 32'h11223344) begin n_err++; $display("FAIL smiss_merge got=%h exp=11223344", o_read_data); end
        tick(); load(32'h50000024, 32'h24);
        @(negedge clk);
        n_vec++; if (o_read_data !== 32'h2) begin n_err++; $display("FAIL smiss_elem1 got=%h exp=00000002", o_read_data); end
    endtask

    task automatic test_ack_ignored();
        tick(); no_req(); i_mem_ack = 1'b1; i_mem_rdata = LJ;
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_stall, o_hit} !== 3'b000) begin n_err++; $display("FAIL stray_ack req/stall/hit got=%b exp=000", {o_mem_req, o_stall, o_hit}); end
        tick(); i_mem_ack = 1'b0; load(32'h40000010, 32'h10);
        @(negedge clk);
        n_vec++; if (o_hit !== 1'b1 || o_read_data !== 32'h44) begin n_err++; $display("FAIL stray_ack_data hit=%0b data=%h exp 1/00000044", o_hit, o_read_data); end
        n_vec++; if (o_read_data === 32'h0 && o_hit === 1'b0) begin n_err++; $display("FAIL noreq_data got=%h exp=00000044", o_read_data); end
    endtask

    task automatic test_reset_mid();
        tick(); rnd = 1'b0; load(32'h20000010, 32'h10);
        tick();
        @(negedge clk);
        n_vec++; if (o_mem_req !== 1'b1) begin n_err++; $display("FAIL mid_req_before got=%0b exp=1", o_mem_req); end
        rst = 1'b0;
        tick();
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_stall, o_hit} !== 3'b000) begin n_err++; $display("FAIL mid_rst req/stall/hit got=%b exp=000", {o_mem_req, o_stall, o_hit}); end
        tick(); rst = 1'b1; load(32'h30000010, 32'h10);
        @(negedge clk);
        n_vec++; if ({o_hit, o_stall} !== 2'b01) begin n_err++; $display("FAIL reload_miss hit/stall got=%b exp=01", {o_hit, o_stall}); end
        tick(); i_mem_ack = 1'b1; i_mem_rdata = L3;
        tick(); i_mem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (o_hit !== 1'b1 || o_read_data !== 32'h33) begin n_err++; $display("FAIL reload_final hit=%0b data=%h exp 1/00000033", o_hit, o_read_data); end
    endtask

    task automatic test_replacement();
        logic exp_a;
`ifdef CACHE_WB_PLRU_EN
        exp_a = 1'b1;
`else
        exp_a = 1'b0;
`endif
        rnd = 1'b0;
        fill(32'h60000030, 32'h30, L1);
        fill(32'h70000030, 32'h30, L2);
        @(negedge clk);
        n_vec++; if (o_hit !== 1'b1 || o_read_data !== 32'hA1) begin n_err++; $display("FAIL repl_b hit=%0b data=%h exp 1/000000A1", o_hit, o_read_data); end
        tick(); load(32'h60000030, 32'h30);
        @(negedge clk);
        n_vec++; if (o_hit !== 1'b1 || o_read_data !== 32'h1) begin n_err++; $display("FAIL repl_a hit=%0b data=%h exp 1/00000001", o_hit, o_read_data); end
        tick(); load(32'h80000030, 32'h30);
        tick();
        @(negedge clk);
        n_vec++; if (o_mem_addr !== 32'h80000030 || o_mem_we !== 1'b0) begin n_err++; $display("FAIL repl_c addr=%h we=%0b exp 80000030/0", o_mem_addr, o_mem_we); end
        i_mem_ack = 1'b1; i_mem_rdata = L4;
        tick(); i_mem_ack = 1'b0; load(32'h60000030, 32'h30);
        @(negedge clk);
        n_vec++; if (o_hit !== exp_a) begin n_err++; $display("FAIL repl_victim a_hit=%0b exp=%0b", o_hit, exp_a); end
        tick(); no_req(); rst = 1'b0;
        tick(); rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; rnd = 1'b0; no_req();
        i_va_addr = '0; i_pa_addr = '0; i_write_data = '0; i_byte_en = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        test_reset();
        test_refill();
        test_store_hit();
        test_writeback();
        test_clean_miss();
        test_store_miss();
        test_ack_ignored();
        test_reset_mid();
        test_replacement();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
